// File: rtl/int_arbiter.sv
// Fixed-priority interrupt arbiter: lowest eligible index wins, IDLE/PENDING/ACK handshake with the CPU.
// Optional macro INT_ARBITER_NEST_EN allows higher-priority sources to preempt in-service ones.
module int_arbiter #(
    parameter int NUM_INT = 8,
    parameter int VEC_W   = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_INT-1:0] int_i,
    output logic [NUM_INT-1:0] int_ack_o,
    input  logic [NUM_INT-1:0] int_en_i,
    input  logic               gie_i,
    output logic               irq_o,
    output logic [VEC_W-1:0]   vector_o,
    input  logic               cpu_ack_i,
    input  logic               reti_i,
    output logic [NUM_INT-1:0] isr_o
);

    typedef enum logic [1:0] {IDLE, PENDING, ACK} state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_INT-1:0] isr_q, isr_d;
    logic [NUM_INT-1:0] isr_low;
    logic [NUM_INT-1:0] unblocked;
    logic [NUM_INT-1:0] eligible;
    logic [NUM_INT-1:0] vec_oh;

    function automatic logic [VEC_W-1:0] lowest_idx(input logic [NUM_INT-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (v[i]) idx = VEC_W'(i);
        end
        return idx;
    endfunction

    // Isolate the lowest set in-service bit (highest-priority active handler).
    assign isr_low = isr_q & (~isr_q + NUM_INT'(1));

`ifdef INT_ARBITER_NEST_EN
    assign unblocked = (isr_q == '0) ? '1 : (isr_low - NUM_INT'(1));
`else
    assign unblocked = (isr_q == '0) ? '1 : '0;
`endif

    assign eligible = int_i & int_en_i & {NUM_INT{gie_i}} & unblocked;
    assign vec_oh   = NUM_INT'(1) << vec_q;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        isr_d   = isr_q;
        if (reti_i) isr_d = isr_q & ~isr_low;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = PENDING;
                    vec_d   = lowest_idx(eligible);
                end
            end
            PENDING: begin
                // CPU acceptance beats a simultaneous withdrawal of the source.
                if (cpu_ack_i) begin
                    state_d = ACK;
                    isr_d   = isr_d | vec_oh;
                end else if (!(|(eligible & vec_oh))) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
            isr_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            isr_q   <= isr_d;
        end
    end

    assign irq_o     = (state_q == PENDING);
    assign int_ack_o = (state_q == ACK) ? vec_oh : '0;
    assign vector_o  = vec_q;
    assign isr_o     = isr_q;

endmodule
